// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with clear, clamped load, wrap/saturate limits,
// terminal-count flag and registered overflow pulse. Optional prescaler: MOD_COUNTER_PRESCALER_EN.
module mod_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter bit              SATURATE = 1'b0,
  parameter int unsigned     PRESCALE = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal_count,
  output logic             overflow
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS out of range");
  end
  if (PRESCALE < 2 || PRESCALE > 65536) begin : g_bad_prescale
    $error("mod_counter: PRESCALE out of range");
  end

  // One spare bit so MODULUS = 2**WIDTH is representable in every compare.
  localparam logic [WIDTH:0] MOD_V = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] ZERO  = '0;
  localparam logic [WIDTH:0] MAX_V = MOD_V - ONE;

  logic [WIDTH:0] cnt_q, cnt_d, ld_x;
  logic           ovf_d;
  logic           step;

  assign ld_x           = {1'b0, load_value};
  assign counter_out    = cnt_q[WIDTH-1:0];
  assign terminal_count = up_down ? (cnt_q == MAX_V) : (cnt_q == ZERO);

`ifdef MOD_COUNTER_PRESCALER_EN
  localparam int unsigned PS_W  = $clog2(PRESCALE);
  localparam int unsigned PS_M1 = PRESCALE - 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_M1[PS_W-1:0];
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_q;
  logic            tick;

  assign tick = enable & (ps_q == PS_LAST);
  assign step = tick;

  // Counts enabled cycles only; clear/load restart the step interval.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            ps_q <= '0;
    else if (clear || load)  ps_q <= '0;
    else if (enable)         ps_q <= tick ? '0 : ps_q + PS_ONE;
  end
`else
  assign step = enable;
`endif

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (clear) begin
      cnt_d = ZERO;
    end else if (load) begin
      cnt_d = (ld_x > MAX_V) ? MAX_V : ld_x;
    end else if (step) begin
      // A step attempted at the limit in the current direction is an overflow.
      ovf_d = terminal_count;
      if (up_down)
        cnt_d = (cnt_q < MAX_V) ? cnt_q + ONE : (SATURATE ? cnt_q : ZERO);
      else
        cnt_d = (cnt_q > ZERO) ? cnt_q - ONE : (SATURATE ? cnt_q : MAX_V);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= ZERO;
      overflow <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Randomised + directed bench for mod_counter: three configurations (wrap/saturate at
// modulus 10, full 8-bit range) checked against an integer reference model.
module tb_mod_counter;

`ifdef MOD_COUNTER_PRESCALER_EN
  localparam bit PS_ON = 1'b1;
`else
  localparam bit PS_ON = 1'b0;
`endif
  localparam int PS  = 4;
  localparam int PSF = PS_ON ? PS : 1;

  localparam int NI = 3;
  localparam int WIDS [NI] = '{4, 4, 8};
  localparam int MODS [NI] = '{10, 10, 256};
  localparam bit SATS [NI] = '{1'b0, 1'b1, 1'b0};

  logic       clock = 1'b0;
  logic       reset_n, clear, enable, up_down, load;
  logic [7:0] load_value;
  logic [3:0] co_w, co_s;
  logic [7:0] co_f;
  logic       tc_w, tc_s, tc_f, ov_w, ov_s, ov_f;

  int m_cnt [NI];
  int m_ps  [NI];
  bit m_ovf [NI];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .PRESCALE(PS)) u_wrap (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value[3:0]), .counter_out(co_w),
    .terminal_count(tc_w), .overflow(ov_w));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .PRESCALE(PS)) u_sat (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value[3:0]), .counter_out(co_s),
    .terminal_count(tc_s), .overflow(ov_s));

  mod_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0), .PRESCALE(PS)) u_full (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .counter_out(co_f),
    .terminal_count(tc_f), .overflow(ov_f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_ps[i] = 0; m_ovf[i] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural model, from the rules in plain integer terms.
  task automatic model_edge(input int i);
    int lim, v;
    bit tick;
    lim = MODS[i] - 1;
    m_ovf[i] = 1'b0;
    if (clear) begin
      m_cnt[i] = 0; m_ps[i] = 0;
    end else if (load) begin
      v = int'(load_value) % (1 << WIDS[i]);
      m_cnt[i] = (v > lim) ? lim : v;
      m_ps[i] = 0;
    end else if (enable) begin
      tick = 1'b1;
      if (PS_ON) begin
        tick = (m_ps[i] + 1 == PS);
        m_ps[i] = tick ? 0 : m_ps[i] + 1;
      end
      if (tick) begin
        if (up_down) begin
          if (m_cnt[i] == lim) begin m_ovf[i] = 1'b1; m_cnt[i] = SATS[i] ? lim : 0; end
          else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin m_ovf[i] = 1'b1; m_cnt[i] = SATS[i] ? 0 : lim; end
          else m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [7:0] oc;
    logic       ot, oo;
    int         lim;
    for (int i = 0; i < NI; i++) begin
      case (i)
        0:       begin oc = {4'b0, co_w}; ot = tc_w; oo = ov_w; end
        1:       begin oc = {4'b0, co_s}; ot = tc_s; oo = ov_s; end
        default: begin oc = co_f;         ot = tc_f; oo = ov_f; end
      endcase
      lim = MODS[i] - 1;
      chk($sformatf("%s u%0d count", ph, i), 32'(oc), 32'(m_cnt[i]));
      chk($sformatf("%s u%0d overflow", ph, i), 32'(oo), 32'(m_ovf[i]));
      chk($sformatf("%s u%0d tc", ph, i), 32'(ot),
          32'(up_down ? (m_cnt[i] == lim) : (m_cnt[i] == 0)));
    end
  endtask

  task automatic cyc(input string ph);
    @(posedge clock);
    if (reset_n) for (int i = 0; i < NI; i++) model_edge(i);
    #1 check_all(ph);
  endtask

  initial begin
    int guard;
    reset_n = 1'b0; clear = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0;
    load_value = '0;
    model_reset();
    #2 check_all("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Count to 5, then reset asynchronously between edges.
    enable = 1'b1;
    guard = 0;
    while (m_cnt[0] != 5 && guard < 100) begin cyc("pre_reset"); guard++; end
    chk("reach5", 32'(co_w), 32'd5);
    #3 reset_n = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3 * PSF) cyc("post_reset");

    // Wrap up through 9 -> 0.
    clear = 1'b1; cyc("clear");
    clear = 1'b0;
    repeat (12 * PSF) cyc("wrap_up");

    // Saturate/wrap down from 2.
    load_value = 8'd2; load = 1'b1; cyc("load2");
    load = 1'b0; up_down = 1'b0;
    repeat (4 * PSF) cyc("down");

    // Priority and clamp.
    clear = 1'b1; load = 1'b1; load_value = 8'd7; cyc("clear_load");
    clear = 1'b0; load_value = 8'd12; enable = 1'b0; cyc("load12");
    load_value = 8'd3; enable = 1'b1; cyc("load3_en");
    load = 1'b0;
    repeat (PSF) cyc("after_load3");

    // Direction flip at the top.
    up_down = 1'b1; load_value = 8'd9; load = 1'b1; cyc("load9");
    load = 1'b0; enable = 1'b0;
    #1 check_all("tc_up");
    up_down = 1'b0;
    #1 check_all("tc_flip");
    enable = 1'b1;
    repeat (PSF) cyc("flip_step");

    // Randomised traffic, with occasional mid-cycle resets.
    for (int n = 0; n < 900; n++) begin
      clear      = ($urandom_range(31) == 0);
      load       = ($urandom_range(15) == 0);
      enable     = ($urandom_range(3) != 0);
      load_value = 8'($urandom);
      if ($urandom_range(7) == 0) up_down = ~up_down;
      #1 check_all("rnd_in");
      if ($urandom_range(199) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1 check_all("rnd_reset");
        @(negedge clock);
        reset_n = 1'b1;
      end
      cyc("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter, the successor to the team's fixed 4-bit up counter. It provides configurable width and modulus, direction control, synchronous clear and parallel load, and wrap or saturate behaviour at the range limits. It also drives a terminal-count flag and a registered overflow pulse. It sits in timer, event-counting and rate-generation paths, and its outputs feed downstream control logic directly.

## Interface
- WIDTH, 8, counter width in bits; 1 ≤ WIDTH ≤ 32.
- MODULUS, 256, count range is 0 .. MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
- PRESCALE, 4, enabled cycles per count step; used only with MOD_COUNTER_PRESCALER_EN; 2 ≤ PRESCALE ≤ 65536.

- clock  input  1  design clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear to 0, active high.
- enable  input  1  count enable, active high.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load, active high.
- load_value  input  WIDTH  value loaded when load = 1.
- counter_out  output  WIDTH  registered count value.
- terminal_count  output  1  combinational; 1 when counter_out = MODULUS-1 and up_down = 1, or counter_out = 0 and up_down = 0.
- overflow  output  1  registered single-cycle pulse for each step attempted at a limit.

## Operation
- Priority per edge is clear > load > step.
- step = enable when the prescaler is compiled out; otherwise step = enable AND prescaler tick.
- Up step: if counter_out < MODULUS-1, counter_out + 1; otherwise 0 (SATURATE = 0) or hold (SATURATE = 1).
- Down step: if counter_out > 0, counter_out - 1; otherwise MODULUS-1 (SATURATE = 0) or hold (SATURATE = 1).
- overflow = 1 on the edge after any step taken while terminal_count = 1, in both wrap and saturate modes. It is 0 otherwise, including on clear/load cycles.
- Load: load_value ≥ MODULUS is clamped to MODULUS-1. Load while enable = 1 still loads, and no step occurs that cycle.
- Direction change takes effect on the next step. terminal_count follows up_down combinationally.
- counter_out never leaves 0 .. MODULUS-1.
- All arithmetic is done at WIDTH+1 bits internally, so MODULUS = 2**WIDTH does not overflow.

## Timing
- Reset: while reset_n = 0, counter_out = 0, overflow = 0 and the prescaler = 0, immediately and independent of clock.
- Reset release must be synchronous to clock; release is synchronised upstream.
- Latency: a step, load or clear sampled at edge N is visible on counter_out after edge N. overflow is visible after the same edge.
- Reset asserted mid-count or mid-prescale discards all state. The first step after release needs a full PRESCALE enabled cycles.
- enable low freezes both the counter and the prescaler. No state changes without enable, load, clear or reset.

## Configuration
- MOD_COUNTER_PRESCALER_EN defined:
  - A prescaler of ceil(log2(PRESCALE)) bits counts enabled cycles.
  - It generates a tick on every PRESCALE-th enabled cycle and returns to 0 on that cycle.
  - The prescaler is cleared by reset_n, clear and load.
  - The counter steps only on ticks.
- MOD_COUNTER_PRESCALER_EN undefined: no prescaler logic. The counter steps on every enabled cycle, and PRESCALE is ignored.

## Test plan
- Reset: hold reset_n = 0 mid-count at value 5, asynchronously between edges -> counter_out = 0 and overflow = 0 immediately. Release, then 3 enabled up cycles -> 1, 2, 3 (no prescaler).
- Wrap up: WIDTH = 4, MODULUS = 10, SATURATE = 0, enable = 1, up_down = 1 from 0 -> sequence 0..9, then 0. overflow is high exactly one cycle after the 9→0 edge. terminal_count = 1 while the count is 9.
- Saturate down: WIDTH = 4, MODULUS = 10, SATURATE = 1, load 2, then count down 4 cycles -> 1, 0, 0, 0. overflow pulses on each of the last two steps.
- Priority/clamp: WIDTH = 4, MODULUS = 10, clear = 1 and load = 1 together -> 0. Load 12 -> 9. Load 3 with enable = 1 -> 3, with no step that cycle.
- Prescaler (macro defined, PRESCALE = 4): enable high 12 cycles -> counter_out steps 0→1→2→3, once every 4 cycles. Load mid-prescale -> the next step comes 4 enabled cycles after the load.
- Direction flip: WIDTH = 4, MODULUS = 10, at counter_out = 9, up_down 1→0 -> terminal_count drops combinationally and the next step gives 8 with no overflow.
